// File: rtl/eyeriss.sv
// Eyeriss-style control shell: scan-loaded id configuration, three on-chip GLBs,
// DRAM forward/backward streaming and an elementwise MAC pass into the psum GLB.
module eyeriss #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int GLB_DEPTH  = 2 ** ADDR_WIDTH,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  scan_en,
    input  logic                  scan_in,
    output logic                  scan_out,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  start_pass,
    output logic                  pass_done,
    input  logic                  ofmap_dump,
    output logic                  dump_done,
    input  logic [ADDR_WIDTH:0]   words_num,
    input  logic                  start_forward,
    input  logic [1:0]            transfer_type,
    output logic                  re_from_dram,
    input  logic [DATA_WIDTH-1:0] rdata_from_dram,
    input  logic                  valid_from_dram,
    input  logic                  start_backward,
    output logic                  we_to_dram,
    output logic [DATA_WIDTH-1:0] wdata_to_dram,
    output logic                  transfer_done,
    output logic [ID_WIDTH-1:0]   filter_ids,
    output logic [ID_WIDTH-1:0]   filter_channel_ids,
    output logic [ID_WIDTH-1:0]   ifmap_ids,
    output logic [ID_WIDTH-1:0]   ifmap_channel_ids,
    output logic [ID_WIDTH-1:0]   psum_ids,
    output logic [ID_WIDTH-1:0]   psum_channel_ids
);

    localparam int CFG_W = 6 * ID_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DEPTH_N = cnt_t'(GLB_DEPTH);
    localparam cnt_t ONE     = cnt_t'(1);

    typedef enum logic [2:0] {IDLE, READY, FWD, PASS, BWD, DUMP} state_t;

    logic [CFG_W-1:0] cfg_q;

    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset) begin
            cfg_q <= '0;
        end else if (scan_en) begin
            cfg_q <= {cfg_q[CFG_W-2:0], scan_in};
        end
    end

    assign scan_out           = cfg_q[CFG_W-1];
    assign filter_ids         = cfg_q[6*ID_WIDTH-1 -: ID_WIDTH];
    assign filter_channel_ids = cfg_q[5*ID_WIDTH-1 -: ID_WIDTH];
    assign ifmap_ids          = cfg_q[4*ID_WIDTH-1 -: ID_WIDTH];
    assign ifmap_channel_ids  = cfg_q[3*ID_WIDTH-1 -: ID_WIDTH];
    assign psum_ids           = cfg_q[2*ID_WIDTH-1 -: ID_WIDTH];
    assign psum_channel_ids   = cfg_q[1*ID_WIDTH-1 -: ID_WIDTH];

    state_t                 state_q;
    cnt_t                   n_q;
    cnt_t                   cnt_q;
    cnt_t                   n_sel;
    logic [ADDR_WIDTH-1:0]  wa_q;
    logic [1:0]             type_q;
    logic                   re_q;
    logic                   pv_q;
    logic                   sv_q;
    logic                   xfer_done_q;
    logic                   pass_done_q;
    logic                   dump_done_q;
    logic                   done_q;

    assign n_sel = (words_num > DEPTH_N) ? DEPTH_N : words_num;

    // One FSM drives every counter and pulse; pv_q marks a PASS read whose data
    // arrives next cycle, sv_q marks a psum word being presented to DRAM.
    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            wa_q        <= '0;
            type_q      <= '0;
            re_q        <= 1'b0;
            pv_q        <= 1'b0;
            sv_q        <= 1'b0;
            xfer_done_q <= 1'b0;
            pass_done_q <= 1'b0;
            dump_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            xfer_done_q <= 1'b0;
            pass_done_q <= 1'b0;
            dump_done_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) state_q <= READY;
                end
                READY: begin
                    cnt_q <= '0;
                    pv_q  <= 1'b0;
                    sv_q  <= 1'b0;
                    if (start_forward || start_pass || start_backward || ofmap_dump) begin
                        n_q    <= n_sel;
                        type_q <= transfer_type;
                    end
                    if (start_forward) begin
                        if (n_sel == '0) begin
                            xfer_done_q <= 1'b1;
                        end else begin
                            state_q <= FWD;
                            re_q    <= 1'b1;
                        end
                    end else if (start_pass) begin
                        if (n_sel == '0) pass_done_q <= 1'b1;
                        else             state_q     <= PASS;
                    end else if (start_backward) begin
                        if (n_sel == '0) xfer_done_q <= 1'b1;
                        else             state_q     <= BWD;
                    end else if (ofmap_dump) begin
                        if (n_sel == '0) begin
                            dump_done_q <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= DUMP;
                        end
                    end
                end
                FWD: begin
                    if (re_q && valid_from_dram) begin
                        cnt_q <= cnt_q + ONE;
                        if (cnt_q == n_q - ONE) begin
                            re_q        <= 1'b0;
                            xfer_done_q <= 1'b1;
                            state_q     <= READY;
                        end
                    end
                end
                PASS: begin
                    if (cnt_q != n_q) begin
                        cnt_q <= cnt_q + ONE;
                        pv_q  <= 1'b1;
                        wa_q  <= cnt_q[ADDR_WIDTH-1:0];
                    end else begin
                        pv_q <= 1'b0;
                        if (pv_q) begin
                            pass_done_q <= 1'b1;
                            state_q     <= READY;
                        end
                    end
                end
                BWD, DUMP: begin
                    if (cnt_q != n_q) begin
                        cnt_q <= cnt_q + ONE;
                        sv_q  <= 1'b1;
                    end else begin
                        sv_q <= 1'b0;
                        if (sv_q) begin
                            if (state_q == DUMP) begin
                                dump_done_q <= 1'b1;
                                done_q      <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                xfer_done_q <= 1'b1;
                                state_q     <= READY;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign re_from_dram  = re_q;
    assign transfer_done = xfer_done_q;
    assign pass_done     = pass_done_q;
    assign dump_done     = dump_done_q;
    assign done          = done_q;

    logic [DATA_WIDTH-1:0] ifmap_mem  [GLB_DEPTH];
    logic [DATA_WIDTH-1:0] filter_mem [GLB_DEPTH];
    logic [DATA_WIDTH-1:0] psum_mem   [GLB_DEPTH];

    logic [DATA_WIDTH-1:0] ifmap_rd_q;
    logic [DATA_WIDTH-1:0] filter_rd_q;
    logic [DATA_WIDTH-1:0] psum_rd_q;

    logic                  fwd_wr;
    logic                  pass_wr;
    logic                  ifmap_we;
    logic                  filter_we;
    logic                  psum_we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] psum_waddr;
    logic [DATA_WIDTH-1:0] psum_wdata;

    assign addr       = cnt_q[ADDR_WIDTH-1:0];
    assign fwd_wr     = (state_q == FWD) && re_q && valid_from_dram;
    assign pass_wr    = (state_q == PASS) && pv_q;
    assign ifmap_we   = fwd_wr && (type_q == 2'd0);
    assign filter_we  = fwd_wr && (type_q == 2'd1);
    assign psum_we    = (fwd_wr && (type_q == 2'd2)) || pass_wr;
    assign psum_waddr = pass_wr ? wa_q : addr;
    assign psum_wdata = pass_wr ? (psum_rd_q + ifmap_rd_q * filter_rd_q) : rdata_from_dram;

    always_ff @(posedge core_clk) begin
        if (ifmap_we) ifmap_mem[addr] <= rdata_from_dram;
        ifmap_rd_q <= ifmap_mem[addr];
    end

    always_ff @(posedge core_clk) begin
        if (filter_we) filter_mem[addr] <= rdata_from_dram;
        filter_rd_q <= filter_mem[addr];
    end

    always_ff @(posedge core_clk) begin
        if (psum_we) psum_mem[psum_waddr] <= psum_wdata;
        psum_rd_q <= psum_mem[addr];
    end

    assign we_to_dram    = sv_q;
    assign wdata_to_dram = sv_q ? psum_rd_q : '0;

endmodule

// File: tb/tb_eyeriss.sv
// Directed-plus-random bench for eyeriss; GLB contents are tracked by a plain
// array model and every output is compared against it at the falling edge.
module tb_eyeriss;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int IW    = 4;

    logic          core_clk = 1'b0;
    logic          reset = 1'b1;
    logic          scan_en = 1'b0;
    logic          scan_in = 1'b0;
    logic          start = 1'b0;
    logic          start_pass = 1'b0;
    logic          ofmap_dump = 1'b0;
    logic          start_forward = 1'b0;
    logic          start_backward = 1'b0;
    logic [AW:0]   words_num = '0;
    logic [1:0]    transfer_type = '0;
    logic [DW-1:0] rdata_from_dram = '0;
    logic          valid_from_dram = 1'b0;

    logic          scan_out, busy, done, pass_done, dump_done;
    logic          re_from_dram, we_to_dram, transfer_done;
    logic [DW-1:0] wdata_to_dram;
    logic [IW-1:0] filter_ids, filter_channel_ids, ifmap_ids;
    logic [IW-1:0] ifmap_channel_ids, psum_ids, psum_channel_ids;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ifm_m [DEPTH];
    logic [DW-1:0] flt_m [DEPTH];
    logic [DW-1:0] ps_m  [DEPTH];
    logic [DW-1:0] dq [$];

    eyeriss #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GLB_DEPTH(DEPTH), .ID_WIDTH(IW)) dut (
        .core_clk(core_clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out), .start(start), .busy(busy), .done(done),
        .start_pass(start_pass), .pass_done(pass_done), .ofmap_dump(ofmap_dump),
        .dump_done(dump_done), .words_num(words_num), .start_forward(start_forward),
        .transfer_type(transfer_type), .re_from_dram(re_from_dram),
        .rdata_from_dram(rdata_from_dram), .valid_from_dram(valid_from_dram),
        .start_backward(start_backward), .we_to_dram(we_to_dram),
        .wdata_to_dram(wdata_to_dram), .transfer_done(transfer_done),
        .filter_ids(filter_ids), .filter_channel_ids(filter_channel_ids),
        .ifmap_ids(ifmap_ids), .ifmap_channel_ids(ifmap_channel_ids),
        .psum_ids(psum_ids), .psum_channel_ids(psum_channel_ids)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampn(input int wn);
        return (wn > DEPTH) ? DEPTH : wn;
    endfunction

    task automatic open_session();
        start = 1'b1;
        @(negedge core_clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    // mode 0: valid every cycle, 1: valid low on alternate cycles, 2: random gaps
    task automatic fwd(input int ttype, input int wn, input int mode);
        int nn, k, c, pulses;
        bit re_bad, v;
        logic [DW-1:0] d;
        nn = clampn(wn);
        k = 0; c = 0; pulses = 0; re_bad = 1'b0;
        start_forward = 1'b1;
        transfer_type = 2'(ttype);
        words_num = 9'(wn);
        valid_from_dram = 1'b1;
        rdata_from_dram = 16'hDEAD;
        @(negedge core_clk);
        start_forward = 1'b0;
        valid_from_dram = 1'b0;
        while (k < nn && c < 4 * nn + 8) begin
            if (re_from_dram !== 1'b1) re_bad = 1'b1;
            if (transfer_done === 1'b1) pulses++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : ($urandom_range(0, 3) != 0);
            d = (k < dq.size()) ? dq[k] : 16'($urandom);
            valid_from_dram = v;
            rdata_from_dram = d;
            if (v) begin
                case (ttype)
                    0: ifm_m[k] = d;
                    1: flt_m[k] = d;
                    2: ps_m[k] = d;
                    default: ;
                endcase
                k++;
            end
            @(negedge core_clk);
            c++;
        end
        valid_from_dram = 1'b1;
        rdata_from_dram = 16'hBEEF;
        chk("fwd_words", 32'(k), 32'(nn));
        chk("fwd_re_held", 32'(re_bad), 32'd0);
        chk("fwd_re_drop", 32'(re_from_dram), 32'd0);
        chk("fwd_tdone", 32'(transfer_done), 32'd1);
        if (transfer_done === 1'b1) pulses++;
        re_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            if (transfer_done === 1'b1) pulses++;
            if (re_from_dram !== 1'b0) re_bad = 1'b1;
        end
        valid_from_dram = 1'b0;
        chk("fwd_pulses", 32'(pulses), 32'd1);
        chk("fwd_re_quiet", 32'(re_bad), 32'd0);
    endtask

    task automatic pass(input int wn, input logic [1:0] extra);
        int nn, pulses, first;
        bit io_bad;
        nn = clampn(wn);
        pulses = 0; first = 0; io_bad = 1'b0;
        start_pass = 1'b1;
        start_backward = extra[0];
        ofmap_dump = extra[1];
        words_num = 9'(wn);
        @(negedge core_clk);
        start_pass = 1'b0;
        start_backward = 1'b0;
        ofmap_dump = 1'b0;
        for (int c = 1; c <= 2 * nn + 8; c++) begin
            if (pass_done === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (we_to_dram !== 1'b0 || re_from_dram !== 1'b0) io_bad = 1'b1;
            @(negedge core_clk);
        end
        for (int i = 0; i < nn; i++) ps_m[i] = 16'(ps_m[i] + ifm_m[i] * flt_m[i]);
        chk("pass_pulses", 32'(pulses), 32'd1);
        chk("pass_latency", 32'(first >= 1 && first <= 2 * nn + 4), 32'd1);
        chk("pass_no_io", 32'(io_bad), 32'd0);
        chk("pass_busy", 32'(busy), 32'd1);
    endtask

    task automatic stream(input bit dump, input int wn);
        int nn, w, first, last, pulses, pc, dpulses, dc;
        bit zbad, rebad;
        nn = clampn(wn);
        w = 0; first = 0; last = 0; pulses = 0; pc = 0; dpulses = 0; dc = 0;
        zbad = 1'b0; rebad = 1'b0;
        start_backward = !dump;
        ofmap_dump = dump;
        words_num = 9'(wn);
        @(negedge core_clk);
        start_backward = 1'b0;
        ofmap_dump = 1'b0;
        for (int c = 1; c <= nn + 6; c++) begin
            if (we_to_dram === 1'b1) begin
                w++;
                if (first == 0) first = c;
                last = c;
                if (w <= nn) chk("stream_word", 32'(wdata_to_dram), 32'(ps_m[w-1]));
            end else if (wdata_to_dram !== '0) begin
                zbad = 1'b1;
            end
            if (re_from_dram !== 1'b0) rebad = 1'b1;
            if ((dump ? dump_done : transfer_done) === 1'b1) begin
                pulses++;
                pc = c;
            end
            if (done === 1'b1) begin
                dpulses++;
                dc = c;
            end
            // a forward command while streaming must be ignored
            start_forward = (c == 1 && nn > 0);
            valid_from_dram = (c == 1 && nn > 0);
            @(negedge core_clk);
        end
        chk("stream_count", 32'(w), 32'(nn));
        if (nn > 0) begin
            chk("stream_consec", 32'(last - first + 1), 32'(nn));
            chk("stream_first", 32'(first <= 2), 32'd1);
        end
        chk("stream_pulses", 32'(pulses), 32'd1);
        chk("stream_pulse_cyc", 32'(pc), 32'((nn > 0) ? last + 1 : 1));
        chk("stream_zero_idle", 32'(zbad), 32'd0);
        chk("stream_no_re", 32'(rebad), 32'd0);
        if (dump) begin
            chk("dump_done_pulses", 32'(dpulses), 32'd1);
            chk("dump_done_align", 32'(dc), 32'(pc));
            chk("dump_busy_low", 32'(busy), 32'd0);
        end else begin
            chk("bwd_no_done", 32'(dpulses), 32'd0);
            chk("bwd_busy", 32'(busy), 32'd1);
        end
    endtask

    initial begin
        logic [23:0] pat;
        bit idle_bad;
        int tdone_after;

        #1 reset = 1'b0;
        scan_en = 1'b1;
        scan_in = 1'b1;
        repeat (3) @(negedge core_clk);
        chk("rst_ctrl", 32'({busy, done, pass_done, dump_done, transfer_done, re_from_dram, we_to_dram}), 32'd0);
        chk("rst_wdata", 32'(wdata_to_dram), 32'd0);
        chk("rst_scan_out", 32'(scan_out), 32'd0);
        chk("rst_ids", 32'({filter_ids, filter_channel_ids, ifmap_ids, ifmap_channel_ids, psum_ids, psum_channel_ids}), 32'd0);
        scan_en = 1'b0;
        reset = 1'b1;
        @(negedge core_clk);

        pat = 24'h123456;
        scan_en = 1'b1;
        for (int i = 23; i >= 0; i--) begin
            scan_in = pat[i];
            @(negedge core_clk);
        end
        scan_en = 1'b0;
        chk("scan_fields", 32'({filter_ids, filter_channel_ids, ifmap_ids, ifmap_channel_ids, psum_ids, psum_channel_ids}), 32'h123456);
        chk("scan_filter_ids", 32'(filter_ids), 32'd1);
        chk("scan_psum_ch_ids", 32'(psum_channel_ids), 32'd6);
        chk("scan_out", 32'(scan_out), 32'd0);

        chk("idle_busy", 32'(busy), 32'd0);
        open_session();

        pat = 24'($urandom);
        scan_en = 1'b1;
        for (int i = 23; i >= 0; i--) begin
            scan_in = pat[i];
            @(negedge core_clk);
        end
        scan_en = 1'b0;
        chk("scan_rand_ifmap_ids", 32'(ifmap_ids), 32'(pat[15:12]));
        chk("scan_rand_out", 32'(scan_out), 32'(pat[23]));

        dq.delete();
        fwd(0, DEPTH, 2);
        fwd(1, DEPTH, 2);
        fwd(2, 300, 0);
        stream(1'b0, 511);

        dq.delete();
        dq.push_back(16'd10); dq.push_back(16'd20); dq.push_back(16'd30); dq.push_back(16'd40);
        fwd(0, 4, 1);

        dq.delete(); dq.push_back(16'd1); dq.push_back(16'd2); dq.push_back(16'd3);
        fwd(0, 3, 0);
        dq.delete(); dq.push_back(16'd4); dq.push_back(16'd5); dq.push_back(16'd6);
        fwd(1, 3, 1);
        dq.delete(); dq.push_back(16'd7); dq.push_back(16'd8); dq.push_back(16'd9);
        fwd(2, 3, 2);
        pass(3, 2'b00);
        stream(1'b0, 3);

        dq.delete(); dq.push_back(16'h0100);
        fwd(0, 1, 0);
        fwd(1, 1, 0);
        dq.delete(); dq.push_back(16'd5);
        fwd(2, 1, 0);
        pass(1, 2'b00);
        stream(1'b0, 1);

        dq.delete();
        fwd(3, 5, 0);
        fwd(0, 0, 0);
        pass(0, 2'b00);
        stream(1'b0, 0);
        pass(2, 2'b11);
        stream(1'b0, 4);

        for (int it = 0; it < 4; it++) begin
            fwd(0, $urandom_range(1, 24), 2);
            fwd(1, $urandom_range(1, 24), 2);
            fwd(2, $urandom_range(1, 24), 2);
            pass($urandom_range(1, 24), 2'($urandom_range(0, 3)));
            stream(1'b0, $urandom_range(0, 24));
        end

        stream(1'b1, 2);

        idle_bad = 1'b0;
        start_forward = 1'b1; start_pass = 1'b1; start_backward = 1'b1; ofmap_dump = 1'b1;
        valid_from_dram = 1'b1;
        words_num = 9'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge core_clk);
            if ({busy, re_from_dram, we_to_dram, transfer_done, pass_done, dump_done, done} !== 7'd0) idle_bad = 1'b1;
        end
        start_forward = 1'b0; start_pass = 1'b0; start_backward = 1'b0; ofmap_dump = 1'b0;
        valid_from_dram = 1'b0;
        chk("idle_cmds_ignored", 32'(idle_bad), 32'd0);

        open_session();
        start_forward = 1'b1;
        transfer_type = 2'd3;
        words_num = 9'd10;
        @(negedge core_clk);
        start_forward = 1'b0;
        valid_from_dram = 1'b1;
        repeat (3) @(negedge core_clk);
        chk("abort_pre_re", 32'(re_from_dram), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_re", 32'(re_from_dram), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ids", 32'({filter_ids, psum_channel_ids}), 32'd0);
        repeat (2) @(negedge core_clk);
        reset = 1'b1;
        tdone_after = 0;
        idle_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge core_clk);
            if (transfer_done !== 1'b0) tdone_after++;
            if (busy !== 1'b0 || re_from_dram !== 1'b0) idle_bad = 1'b1;
        end
        valid_from_dram = 1'b0;
        chk("abort_no_tdone", 32'(tdone_after), 32'd0);
        chk("abort_idle", 32'(idle_bad), 32'd0);
        open_session();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
